tx_arbiter: RTL
===============

Name: tx_arbiter

Overview:
Round-robin scheduler that shares one UART transmitter between NUM_REQ byte producers. It accepts one byte at a time over a valid/ready handshake and issues a single-cycle tx_en pulse with the byte held stable on tx_data. It then blocks further grants for the frame duration plus a programmable inter-frame gap. It sits directly in front of transmitter_module; tx_en/tx_data connect 1:1 to its tx_en/tx_data inputs.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
FRAME_CYCLES, 11, clock cycles from the tx_en pulse (inclusive) until the transmitter is idle again (start + 8 data + parity + stop); must be >= 2
GAP_CYCLES, 1, idle cycles inserted after each frame before the next grant; 0 allowed
IDW, $clog2(NUM_REQ), width of grant_id

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
req_valid  input  NUM_REQ  bit i: requester i has a byte
req_data  input  8*NUM_REQ  byte of requester i on bits [8i+7:8i]
req_ready  output  NUM_REQ  bit i: byte of requester i accepted this cycle (valid&ready = transfer)
tx_en  output  1  one-cycle start pulse to the transmitter
tx_data  output  8  byte to transmit; stable from the pulse until the next accept
busy  output  1  high whenever state != IDLE
grant_id  output  IDW  index of the most recently accepted requester

Behaviour:
- Reset (sync, active-high, overrides everything): state=IDLE, tx_en=0, tx_data=8'h00, busy=0, grant_id=0, rr pointer=0, counters=0. Reset mid-frame abandons the frame with no retry; the transmitter shares the same reset.
- States: IDLE -> SEND -> GAP -> IDLE. GAP is skipped when GAP_CYCLES=0.
- IDLE: winner = first i with req_valid[i]=1, searching from the rr pointer upward with wrap (pointer, pointer+1, ..., NUM_REQ-1, 0, ...).
  - req_ready is combinational: one-hot on the winner in IDLE; all-zero in every other state or when no request is valid.
  - On transfer: register tx_data <= req_data[winner], grant_id <= winner, pointer <= (winner+1) mod NUM_REQ, then go to SEND.
  - With no valid request, stay in IDLE; the pointer is unchanged.
- SEND: lasts exactly FRAME_CYCLES cycles. tx_en=1 in the first SEND cycle only (the cycle after accept, i.e. 1-cycle latency), else 0. A down-counter loads FRAME_CYCLES-1 on entry and exits at 0.
- GAP: lasts exactly GAP_CYCLES cycles, tx_en=0, then returns to IDLE.
- Minimum accept-to-accept spacing is 1+FRAME_CYCLES+GAP_CYCLES cycles (13 at defaults); the accept cycle is the last GAP cycle + 1.
- tx_data and grant_id change only on a transfer; they hold through SEND, GAP and IDLE.
- Requesters must not make req_valid depend on req_ready. A requester may drop valid before it is granted; it gets no grant and causes no state change.
- Simultaneous requests: exactly one grant per accept, never two bits of req_ready high at once.
- Fairness: with all requesters continuously valid, grants cycle 0,1,...,NUM_REQ-1,0,...
- Wrap: pointer after granting NUM_REQ-1 is 0.
- busy=0 only in IDLE, so busy=0 on the same cycle a transfer occurs.

Test Plan:
- Reset then idle: assert reset 2 cycles, no requests, 20 cycles -> tx_en, busy, req_ready stay 0; tx_data=8'h00; grant_id=0.
- Single request: req_valid=4'b0100, byte2=8'hA5 -> req_ready=4'b0100 for 1 cycle; next cycle tx_en=1 (1 cycle), tx_data=8'hA5, grant_id=2; busy high 12 cycles (11 SEND + 1 GAP).
- All four valid continuously (bytes 8'h10,8'h21,8'h32,8'h43) -> grants in order 0,1,2,3,0; tx_en pulses exactly 13 cycles apart; tx_data sequence 10,21,32,43,10.
- Pointer skip/wrap: after a grant to 3, req_valid=4'b1010 -> next grant 1, then 3, then 1.
- Mid-frame reset: reset asserted 5 cycles into SEND -> next cycle busy=0, tx_data=8'h00, pointer=0; with all requesters valid after release, first grant goes to requester 0.
- GAP_CYCLES=0 build with requester 0 always valid -> tx_en pulses every 12 cycles, no idle cycle between SEND and accept beyond the accept cycle.

Source files
------------

// File: rtl/tx_arbiter.sv
// Round-robin front end for a shared UART transmitter: accepts one byte per
// frame from NUM_REQ producers, pulses tx_en once, then holds off grants for frame + gap.
module tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int FRAME_CYCLES = 11,
  parameter int GAP_CYCLES   = 1,
  parameter int IDW          = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_en,
  output logic [7:0]           tx_data,
  output logic                 busy,
  output logic [IDW-1:0]       grant_id
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;

  localparam int CMAX = (FRAME_CYCLES > GAP_CYCLES) ? FRAME_CYCLES : GAP_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] FRAME_LOAD = CW'(FRAME_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD   = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  logic [1:0]     state;
  logic [CW-1:0]  cnt;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] winner;
  logic [IDW-1:0] idx;
  logic           found;
  logic [7:0]     win_byte;
  logic [7:0]     byte_of [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_bytes
    assign byte_of[g] = req_data[8*g +: 8];
  end

  // Scan from the rr pointer upward with wrap; first valid requester wins.
  always_comb begin
    found    = 1'b0;
    winner   = '0;
    idx      = '0;
    win_byte = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = IDW'((32'(ptr) + k) % 32'(NUM_REQ));
      if (!found && req_valid[idx]) begin
        found    = 1'b1;
        winner   = idx;
        win_byte = byte_of[idx];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && found) req_ready[winner] = 1'b1;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      ptr      <= '0;
      tx_en    <= 1'b0;
      tx_data  <= '0;
      grant_id <= '0;
    end else begin
      tx_en <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            tx_data  <= win_byte;
            grant_id <= winner;
            ptr      <= (winner == IDW'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
            cnt      <= FRAME_LOAD;
            tx_en    <= 1'b1;
            state    <= SEND;
          end
        end
        SEND: begin
          if (cnt == '0) begin
            if (GAP_CYCLES == 0) begin
              state <= IDLE;
            end else begin
              cnt   <= GAP_LOAD;
              state <= GAP;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        GAP: begin
          if (cnt == '0) state <= IDLE;
          else           cnt   <= cnt - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
